// File: rtl/execute_stage.sv
// execute_stage: single-cycle ALU for ADD/SUB/logic/shift ops, with a 32-step serial shift-add multiplier.
// MUL holds the stage through IDLE -> BUSY (32 steps) -> DONE. Outputs freeze under holdi; flushi kills.
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] R1i,
  input  logic [31:0] R2i,
  input  logic [31:0] R3i,
  input  logic [3:0]  destRegi,
  input  logic [2:0]  ALUinsi,
  input  logic        wmemi,
  input  logic        rmemi,
  input  logic        wregi,
  input  logic        immi,
  input  logic        wpci,
  input  logic        jmpi,
  input  logic        validi,
  input  logic        holdi,
  input  logic        flushi,
  output logic        stallo,
  output logic [31:0] ALURes,
  output logic [31:0] StoreData,
  output logic [3:0]  DestR,
  output logic        Wmem,
  output logic        Rmem,
  output logic        Wreg,
  output logic        Wpc,
  output logic        Jmp,
  output logic        Z,
  output logic        N,
  output logic        valido
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      r_state, w_next;
  logic [31:0] w_b, w_res, r_a, r_b, r_acc, r_sd;
  logic [4:0]  r_cnt, r_ctl;
  logic [3:0]  r_dest;
  logic        w_mul;
  assign w_b   = immi ? R3i : R2i;
  assign w_mul = ALUinsi == 3'b111;
  always_comb begin
    w_res = '0;
    case (ALUinsi)
      3'b000:  w_res = R1i + w_b;
      3'b001:  w_res = R1i - w_b;
      3'b010:  w_res = R1i & w_b;
      3'b011:  w_res = R1i | w_b;
      3'b100:  w_res = R1i ^ w_b;
      3'b101:  w_res = R1i << w_b[4:0];
      3'b110:  w_res = R1i >> w_b[4:0];
      default: w_res = '0;
    endcase
  end
  // The IDLE term is gated by rst so stallo drops during reset unless holdi is up.
  always_comb begin
    w_next = r_state;
    w_next = flushi ? IDLE :
             r_state == IDLE ? ((validi && w_mul) ? BUSY : IDLE) :
             r_state == BUSY ? ((r_cnt == 5'd31) ? DONE : BUSY) :
             (holdi ? DONE : IDLE);
    stallo = holdi || (rst && ((r_state == IDLE && validi && w_mul) || r_state != IDLE));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_acc <= '0;
      r_sd <= '0;
      r_ctl <= '0;
      r_dest <= '0;
      ALURes <= '0;
      StoreData <= '0;
      DestR <= '0;
      {Wmem, Rmem, Wreg, Wpc, Jmp} <= '0;
      Z <= 1'b0;
      N <= 1'b0;
      valido <= 1'b0;
    end else begin
      r_state <= w_next;
      if (flushi) begin
        r_cnt <= '0;
        valido <= 1'b0;
      end else begin
        if (r_state == IDLE && validi && w_mul) begin
          r_a <= R1i;
          r_b <= w_b;
          r_acc <= '0;
          r_cnt <= '0;
          r_sd <= R2i;
          r_dest <= destRegi;
          r_ctl <= {wmemi, rmemi, wregi, wpci, jmpi};
        end
        if (r_state == BUSY) begin
          r_acc <= r_acc + (r_b[0] ? r_a : 32'd0);
          r_a <= r_a << 1;
          r_b <= r_b >> 1;
          r_cnt <= r_cnt + 5'd1;
        end
        if (!holdi) begin
          if (r_state == DONE) begin
            ALURes <= r_acc;
            StoreData <= r_sd;
            DestR <= r_dest;
            {Wmem, Rmem, Wreg, Wpc, Jmp} <= r_ctl;
            Z <= r_acc == 32'd0;
            N <= r_acc[31];
            valido <= 1'b1;
          end else if (r_state == IDLE) begin
            ALURes <= w_res;
            StoreData <= R2i;
            DestR <= destRegi;
            {Wmem, Rmem, Wreg, Wpc, Jmp} <= {wmemi, rmemi, wregi, wpci, jmpi};
            Z <= w_res == 32'd0;
            N <= w_res[31];
            valido <= validi && !w_mul;
          end else begin
            valido <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed and random stimulus against a transaction-level reference model.
module tb_execute_stage;
  logic        clk, rst;
  logic [31:0] R1i, R2i, R3i;
  logic [3:0]  destRegi;
  logic [2:0]  ALUinsi;
  logic        wmemi, rmemi, wregi, immi, wpci, jmpi, validi, holdi, flushi;
  logic        stallo, Wmem, Rmem, Wreg, Wpc, Jmp, Z, N, valido;
  logic [31:0] ALURes, StoreData;
  logic [3:0]  DestR;

  int n_cmp = 0, n_err = 0, n_stall = 0, n_vld = 0;
  logic [31:0] last_res;

  // reference model: expected EX/MEM contents plus a pending multiply
  logic        e_valid;
  logic [31:0] e_res, e_sd, p_res, p_sd;
  logic [3:0]  e_dest, p_dest;
  logic [4:0]  e_ctl, p_ctl;
  int          phase;

  execute_stage dut (
    .clk(clk), .rst(rst), .R1i(R1i), .R2i(R2i), .R3i(R3i), .destRegi(destRegi),
    .ALUinsi(ALUinsi), .wmemi(wmemi), .rmemi(rmemi), .wregi(wregi), .immi(immi),
    .wpci(wpci), .jmpi(jmpi), .validi(validi), .holdi(holdi), .flushi(flushi),
    .stallo(stallo), .ALURes(ALURes), .StoreData(StoreData), .DestR(DestR),
    .Wmem(Wmem), .Rmem(Rmem), .Wreg(Wreg), .Wpc(Wpc), .Jmp(Jmp), .Z(Z), .N(N),
    .valido(valido)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: return a >> b[4:0];
      default: return a * b;
    endcase
  endfunction

  task automatic model_reset();
    e_valid = 0; e_res = 0; e_sd = 0; e_dest = 0; e_ctl = 0; phase = -1;
  endtask

  task automatic model_step();
    logic [31:0] b;
    b = immi ? R3i : R2i;
    if (flushi) begin
      e_valid = 0;
      phase = -1;
    end else if (phase < 0) begin
      if (validi && ALUinsi == 3'd7) begin
        phase = 0;
        p_res = ref_alu(3'd7, R1i, b);
        p_sd = R2i; p_dest = destRegi; p_ctl = {wmemi, rmemi, wregi, wpci, jmpi};
      end
      if (!holdi) begin
        e_valid = validi && ALUinsi != 3'd7;
        if (e_valid) begin
          e_res = ref_alu(ALUinsi, R1i, b);
          e_sd = R2i; e_dest = destRegi; e_ctl = {wmemi, rmemi, wregi, wpci, jmpi};
        end
      end
    end else if (phase < 32) begin
      phase++;
      if (!holdi) e_valid = 0;
    end else if (!holdi) begin
      e_valid = 1; e_res = p_res; e_sd = p_sd; e_dest = p_dest; e_ctl = p_ctl;
      phase = -1;
    end
  endtask

  task automatic tick();
    #1;
    chk("stallo", stallo, holdi || phase >= 0 || (validi && ALUinsi == 3'd7));
    if (stallo) n_stall++;
    model_step();
    @(posedge clk);
    #1;
    chk("valido", valido, e_valid);
    if (e_valid) begin
      chk("ALURes", ALURes, e_res);
      chk("StoreData", StoreData, e_sd);
      chk("DestR", DestR, e_dest);
      chk("ctl", {Wmem, Rmem, Wreg, Wpc, Jmp}, e_ctl);
      chk("ZN", {Z, N}, {e_res == 0, e_res[31]});
    end
    if (valido) begin
      n_vld++;
      last_res = ALURes;
    end
    @(negedge clk);
  endtask

  task automatic set(input logic [2:0] op, input logic [31:0] a, input logic [31:0] r2,
                     input logic [31:0] r3, input logic imm, input logic v);
    ALUinsi = op; R1i = a; R2i = r2; R3i = r3; immi = imm; validi = v;
    destRegi = 4'($urandom); {wmemi, rmemi, wregi, wpci, jmpi} = 5'($urandom);
    holdi = 0; flushi = 0;
  endtask

  task automatic do_reset();
    holdi = 0; flushi = 0; validi = 1; ALUinsi = 3'd7;
    rst = 0;
    #1;
    model_reset();
    chk("rst_valido", valido, 0);
    chk("rst_ALURes", ALURes, 0);
    chk("rst_out", {StoreData, DestR, Wmem, Rmem, Wreg, Wpc, Jmp, Z, N} != 0, 0);
    chk("rst_stallo", stallo, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    rst = 1;
    set(3'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();
    // ADD 5+7
    set(3'd0, 5, 7, 0, 0, 1);
    #1 chk("add_stallo", stallo, 0);
    tick();
    chk("add_res", ALURes, 32'h0000000C);
    chk("add_z", Z, 0);
    // SUB with immediate, back to back
    set(3'd1, 3, 9, 3, 1, 1);
    tick();
    chk("sub_res", ALURes, 0);
    chk("sub_zn", {Z, N}, 2'b10);
    set(3'd5, 1, 0, 31, 1, 1);
    tick();
    chk("shl31", ALURes, 32'h80000000);
    chk("shl31_n", N, 1);
    set(3'd6, 32'h80000000, 31, 0, 0, 1);
    tick();
    chk("shr31", ALURes, 32'h00000001);
    set(3'd5, 32'hDEADBEEF, 0, 0, 0, 1);
    tick();
    chk("shl0", ALURes, 32'hDEADBEEF);
    set(3'd6, 32'hDEADBEEF, 32'hFFFFFFE0, 0, 0, 1);
    tick();
    chk("shr0", ALURes, 32'hDEADBEEF);
    // MUL 1234*5678, stall length and single result pulse
    set(3'd7, 1234, 5678, 0, 0, 1);
    n_stall = 0; n_vld = 0; last_res = 0;
    tick();
    validi = 0;
    for (int i = 0; i < 40; i++) tick();
    chk("mul_stall", n_stall, 34);
    chk("mul_pulses", n_vld, 1);
    chk("mul_res", last_res, 32'h006AE9BC);
    // MUL held in DONE for 5 cycles
    set(3'd7, 1000, 0, 1000, 1, 1);
    tick();
    validi = 0;
    for (int i = 0; i < 32; i++) tick();
    holdi = 1;
    n_vld = 0; n_stall = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("hold_stall", n_stall, 5);
    chk("hold_none", n_vld, 0);
    holdi = 0;
    tick();
    chk("hold_issue", valido, 1);
    chk("hold_res", ALURes, 32'd1000000);
    // flush during BUSY
    set(3'd7, 77, 99, 0, 0, 1);
    tick();
    validi = 0;
    for (int i = 0; i < 10; i++) tick();
    flushi = 1;
    tick();
    chk("flush_v", valido, 0);
    set(3'd0, 2, 2, 0, 0, 1);
    #1 chk("flush_idle_stallo", stallo, 0);
    tick();
    chk("flush_add", ALURes, 4);
    // reset mid-MUL
    set(3'd7, 55, 66, 0, 0, 1);
    tick();
    validi = 0;
    for (int i = 0; i < 10; i++) tick();
    do_reset();
    set(3'd0, 2, 2, 0, 0, 1);
    tick();
    chk("rst_add", ALURes, 4);
    chk("rst_add_v", valido, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op == 3'd7 && $urandom_range(0, 3) != 0) op = 3'($urandom_range(0, 6));
      set(op, $urandom, $urandom, 0, 1'($urandom), $urandom_range(0, 3) != 0);
      R3i = $urandom_range(0, 2) == 0 ? R1i : ($urandom_range(0, 1) ? 32'($urandom_range(0, 31)) : $urandom);
      holdi = $urandom_range(0, 4) == 0;
      flushi = $urandom_range(0, 24) == 0;
      tick();
      if (i % 1000 == 999) do_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst input 1, async active-low reset.
REQ-002 SHALL have ports R1i, R2i, R3i, each input 32: R1i is operand A, R2i is register operand B / store data, R3i is the immediate.
REQ-003 SHALL have destRegi input 4, destination register, and ALUinsi input 3, ALU opcode.
REQ-004 SHALL have wmemi, rmemi, wregi, immi, wpci, jmpi, each input 1, control bits from the ID/EX register.
REQ-005 SHALL have validi input 1, the ID/EX slot holds a live instruction.
REQ-006 SHALL have holdi input 1, downstream (MEM) cannot accept, and flushi input 1, a synchronous kill.
REQ-007 SHALL have stallo output 1, telling upstream to hold the ID/EX register contents.
REQ-008 SHALL have these EX/MEM outputs: ALURes output 32, StoreData output 32, DestR output 4.
REQ-009 SHALL have control outputs Wmem, Rmem, Wreg, Wpc, Jmp, each output 1, plus Z output 1 (zero) and N output 1 (result bit 31).
REQ-010 SHALL have valido output 1, the EX/MEM slot holds a live instruction.

Function
REQ-011 SHALL form operand B as R3i when immi=1, else R2i; StoreData SHALL equal R2i.
REQ-012 SHALL decode ALUinsi: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL by B[4:0], 110 logical SHR by B[4:0], 111 MUL.
REQ-013 SHALL perform all arithmetic mod 2^32, with no carry or overflow output; MUL SHALL keep the low 32 bits of the unsigned product.
REQ-014 SHALL use a three-state FSM: IDLE, BUSY, DONE.
REQ-015 IDLE, non-MUL op, validi=1, holdi=0: SHALL load all outputs at the next edge (latency 1), with valido=1 and Z/N computed from the result.
REQ-016 IDLE, validi=0, holdi=0: SHALL load valido=0 at the next edge; other outputs are don't-care but SHALL be deterministic.
REQ-017 IDLE, MUL op, validi=1: SHALL capture A, B and the controls, clear the 5-bit iteration counter and the accumulator, and go to BUSY.
REQ-018 BUSY: SHALL do one shift-add step per cycle, consuming one multiplier bit LSB-first, and go to DONE after exactly 32 steps.
REQ-019 DONE with holdi=0: SHALL write the product and captured controls to the outputs with valido=1, then return to IDLE.
REQ-020 DONE with holdi=1: SHALL stay in DONE and keep the result.
REQ-021 stallo SHALL be combinational and equal (IDLE and validi and MUL) or BUSY or DONE or holdi.
REQ-022 A MUL SHALL therefore hold stallo=1 for exactly 34 cycles when holdi=0 throughout.
REQ-023 holdi=1 in any state SHALL freeze every output register; BUSY iterations SHALL continue under hold.
REQ-024 flushi=1 SHALL dominate holdi and validi: at the next edge valido=0, FSM to IDLE, counter to 0, any in-flight MUL discarded, and the input slot that cycle ignored.
REQ-025 Shift amounts 0 and 31 SHALL be legal; SHL or SHR by 0 SHALL return A unchanged.
REQ-026 Back-to-back non-MUL instructions SHALL be accepted every cycle with stallo=0.

Reset
REQ-027 rst=0 SHALL immediately clear all outputs to 0, including valido, Z and N, set the FSM to IDLE and clear the counter and accumulator.
REQ-028 stallo SHALL read 0 while rst=0, provided holdi=0.
REQ-029 Reset asserted mid-MUL SHALL abandon the operation; after release the block SHALL accept a new instruction on the first edge.

Verification
REQ-030 ADD: A=5, R2i=7, immi=0, validi=1 -> next edge ALURes=0x0000000C, Z=0, valido=1, stallo=0.
REQ-031 SUB with immediate: A=3, R3i=3, immi=1 -> ALURes=0, Z=1, N=0.
REQ-032 SHL: A=1, B=31 -> ALURes=0x80000000, N=1; SHR of 0x80000000 by 31 -> 0x00000001.
REQ-033 MUL: A=1234, B=5678 -> stallo high for 34 cycles, then ALURes=0x006AE9BC, valido=1 for one cycle.
REQ-034 MUL with holdi raised in DONE for 5 cycles -> outputs frozen and stallo=1, result issued on the first edge after holdi falls.
REQ-035 flushi during BUSY, and rst pulsed mid-MUL -> valido=0, FSM IDLE, and a following ADD 2+2 yields 4 one edge after acceptance.
